// File: rtl/seq_det_n_if.sv
// rtl/seq_det_n_if.sv - control, data and status bundle for the serial pattern detector
interface seq_det_n_if #(
  parameter int LEN   = 3,
  parameter int CNT_W = 8
);
  logic             en;
  logic             x;
  logic [LEN-1:0]   pat;
  logic             pat_ld;
  logic             overlap;
  logic             clr_cnt;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  // Source side: drives samples and control, observes match status
  modport master (
    output en, x, pat, pat_ld, overlap, clr_cnt,
    input  z, match_cnt, cnt_sat
  );

  // Detector side
  modport slave (
    input  en, x, pat, pat_ld, overlap, clr_cnt,
    output z, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_det_n.sv
// rtl/seq_det_n.sv - serial bit-pattern detector with loadable pattern and saturating match counter
module seq_det_n #(
  parameter int             LEN     = 3,
  parameter int             CNT_W   = 8,
  parameter logic [LEN-1:0] RST_PAT = LEN'(3'b011)
) (
  input  logic        clk,
  input  logic        nrst,
  seq_det_n_if.slave  bus
);
  localparam int             FW        = $clog2(LEN + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(LEN);

  logic [LEN-1:0]   hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [LEN-1:0]   pat_q, pat_d;
  logic             z_q, z_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [LEN-1:0]   nh;
  logic [FW-1:0]    nf;
  logic             hit;

  // Shift/fill/pattern update; a pattern load restarts detection and wins over a sample
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    z_d    = 1'b0;
    hit    = 1'b0;
    nh     = {hist_q[LEN-2:0], bus.x};
    nf     = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);
    if (bus.pat_ld) begin
      pat_d  = bus.pat;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.en) begin
      // fill guards against matching on bits left over from before a restart
      hit    = (nf == FILL_FULL) && (nh == pat_q);
      hist_d = nh;
      z_d    = hit;
      fill_d = (hit && !bus.overlap) ? '0 : nf;
    end
  end

  // Match counter: clear first, then count, never wrap past all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr_cnt) begin
      cnt_d = '0;
    end
    if (hit && !(&cnt_d)) begin
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= RST_PAT;
      z_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.z         = z_q;
  assign bus.match_cnt = cnt_q;
  assign bus.cnt_sat   = &cnt_q;
endmodule

// File: tb/tb_seq_det_n.sv
// tb/tb_seq_det_n.sv - directed self-checking bench for seq_det_n
module tb_seq_det_n;
  logic clk;
  logic nrst;
  int   n_cmp;
  int   n_bad;

  seq_det_n_if #(.LEN(3), .CNT_W(8)) ia ();
  seq_det_n_if #(.LEN(3), .CNT_W(2)) ib ();

  seq_det_n #(.LEN(3), .CNT_W(8), .RST_PAT(3'b011)) u_a (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ia.slave)
  );

  seq_det_n #(.LEN(3), .CNT_W(2), .RST_PAT(3'b111)) u_b (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp_a(input logic xb);
    ia.en = 1'b1;
    ia.x  = xb;
    tick();
    ia.en = 1'b0;
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_a(input logic [2:0] p);
    ia.pat    = p;
    ia.pat_ld = 1'b1;
    tick();
    ia.pat_ld = 1'b0;
  endtask

  task automatic clr_a();
    ia.clr_cnt = 1'b1;
    tick();
    ia.clr_cnt = 1'b0;
  endtask

  task automatic chk_a(input string tag, input int ez, input int ecnt);
    check({tag, ".z"}, int'(ia.z), ez);
    check({tag, ".cnt"}, int'(ia.match_cnt), ecnt);
  endtask

  task automatic samp_b(input logic xb, input logic clr);
    ib.en      = 1'b1;
    ib.x       = xb;
    ib.clr_cnt = clr;
    tick();
    ib.en      = 1'b0;
    ib.clr_cnt = 1'b0;
  endtask

  task automatic chk_b(input string tag, input int ez, input int ecnt, input int esat);
    check({tag, ".z"}, int'(ib.z), ez);
    check({tag, ".cnt"}, int'(ib.match_cnt), ecnt);
    check({tag, ".sat"}, int'(ib.cnt_sat), esat);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nrst  = 1'b0;
    ia.en = 1'b0; ia.x = 1'b0; ia.pat = 3'b000; ia.pat_ld = 1'b0; ia.overlap = 1'b1; ia.clr_cnt = 1'b0;
    ib.en = 1'b0; ib.x = 1'b0; ib.pat = 3'b000; ib.pat_ld = 1'b0; ib.overlap = 1'b1; ib.clr_cnt = 1'b0;

    #3;
    chk_a("rst_a", 0, 0);
    check("rst_a.sat", int'(ia.cnt_sat), 0);
    chk_b("rst_b", 0, 0, 0);
    tick();
    tick();
    nrst = 1'b1;
    tick();

    // Default pattern 011
    samp_a(1'b0); chk_a("def1", 0, 0);
    samp_a(1'b1); chk_a("def2", 0, 0);
    samp_a(1'b1); chk_a("def3", 1, 1);
    samp_a(1'b0); chk_a("def4", 0, 1);

    // Pattern 101, overlapping
    load_a(3'b101); chk_a("ld101", 0, 1);
    clr_a();        chk_a("clr", 0, 0);
    samp_a(1'b1); chk_a("ov1", 0, 0);
    samp_a(1'b0); chk_a("ov2", 0, 0);
    samp_a(1'b1); chk_a("ov3", 1, 1);
    samp_a(1'b0); chk_a("ov4", 0, 1);
    samp_a(1'b1); chk_a("ov5", 1, 2);

    // Pattern 101, non-overlapping
    ia.overlap = 1'b0;
    load_a(3'b101);
    clr_a();
    samp_a(1'b1); chk_a("no1", 0, 0);
    samp_a(1'b0); chk_a("no2", 0, 0);
    samp_a(1'b1); chk_a("no3", 1, 1);
    samp_a(1'b0); chk_a("no4", 0, 1);
    samp_a(1'b1); chk_a("no5", 0, 1);

    // en gating: two idle cycles between samples of 0,1,1
    ia.overlap = 1'b1;
    load_a(3'b011);
    samp_a(1'b0); idle_a(2); chk_a("g1", 0, 1);
    check("g1.hist", int'(u_a.hist_q), 0);
    check("g1.fill", int'(u_a.fill_q), 1);
    samp_a(1'b1); idle_a(2); chk_a("g2", 0, 1);
    check("g2.hist", int'(u_a.hist_q), 1);
    check("g2.fill", int'(u_a.fill_q), 2);
    samp_a(1'b1); chk_a("g3", 1, 2);
    idle_a(1);    chk_a("g3w", 0, 2);

    // Pattern load mid-stream restarts fill
    samp_a(1'b0); samp_a(1'b1);
    load_a(3'b011);
    samp_a(1'b1); chk_a("mid1", 0, 2);
    samp_a(1'b0); chk_a("mid2", 0, 2);
    samp_a(1'b1); chk_a("mid3", 0, 2);
    samp_a(1'b1); chk_a("mid4", 1, 3);

    // Asynchronous reset mid-stream, with a non-default pattern loaded
    load_a(3'b101);
    samp_a(1'b0); samp_a(1'b1);
    nrst = 1'b0;
    #1;
    chk_a("arst", 0, 0);
    check("arst.sat", int'(ia.cnt_sat), 0);
    check("arst.hist", int'(u_a.hist_q), 0);
    tick();
    nrst = 1'b1;
    samp_a(1'b1); chk_a("post1", 0, 0);
    samp_a(1'b1); chk_a("post2", 0, 0);
    samp_a(1'b0); chk_a("post3", 0, 0);
    samp_a(1'b1); chk_a("post4", 0, 0);
    samp_a(1'b1); chk_a("post5", 1, 1);

    // Saturating 2-bit counter with constant pattern 111
    samp_b(1'b1, 1'b0); chk_b("sat1", 0, 0, 0);
    samp_b(1'b1, 1'b0); chk_b("sat2", 0, 0, 0);
    samp_b(1'b1, 1'b0); chk_b("sat3", 1, 1, 0);
    samp_b(1'b1, 1'b0); chk_b("sat4", 1, 2, 0);
    samp_b(1'b1, 1'b0); chk_b("sat5", 1, 3, 1);
    samp_b(1'b1, 1'b0); chk_b("sat6", 1, 3, 1);
    samp_b(1'b1, 1'b1); chk_b("clrhit", 1, 1, 0);
    ib.clr_cnt = 1'b1;
    tick();
    ib.clr_cnt = 1'b0;
    chk_b("clr", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
